// File: rtl/muldiv_pkg.sv
// Shared types, constants and the sign-correction helper for the RV32M unit.
package muldiv_pkg;

   typedef enum logic [2:0] {
      OP_MUL    = 3'd0,
      OP_MULH   = 3'd1,
      OP_MULHSU = 3'd2,
      OP_MULHU  = 3'd3,
      OP_DIV    = 3'd4,
      OP_DIVU   = 3'd5,
      OP_REM    = 3'd6,
      OP_REMU   = 3'd7
   } muldiv_op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } muldiv_state_t;

   localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
   localparam logic [31:0] INT_MIN   = 32'h8000_0000;

   // Turns the unsigned magnitude result back into the architectural result.
   // Sign flags are already zero for the unsigned flavours, so no extra gating.
   function automatic logic [31:0] sign_fix(input muldiv_op_t  op,
                                            input logic        neg_a,
                                            input logic        neg_b,
                                            input logic [63:0] prod,
                                            input logic [31:0] quot,
                                            input logic [31:0] rem);
      logic [63:0] p;
      logic [31:0] res;
      p = (neg_a ^ neg_b) ? -prod : prod;
      case (op)
         OP_MUL:                       res = p[31:0];
         OP_MULH, OP_MULHSU, OP_MULHU: res = p[63:32];
         OP_DIV, OP_DIVU:              res = (neg_a ^ neg_b) ? -quot : quot;
         default:                      res = neg_a ? -rem : rem;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/execute_muldiv_if.sv
// ID/EX-to-muldiv handshake: operands and op select in, stall/result out.
interface execute_muldiv_if;
   logic        start_i;
   logic [2:0]  funct3_i;
   logic [31:0] op_a_i;
   logic [31:0] op_b_i;
   logic [4:0]  rd_i;
   logic        flush_i;
   logic        stall_o;
   logic        done_o;
   logic [31:0] result_o;
   logic [4:0]  rd_o;

   // Pipeline / hazard side.
   modport master (
      output start_i, funct3_i, op_a_i, op_b_i, rd_i, flush_i,
      input  stall_o, done_o, result_o, rd_o
   );

   // Multiply/divide unit side.
   modport slave (
      input  start_i, funct3_i, op_a_i, op_b_i, rd_i, flush_i,
      output stall_o, done_o, result_o, rd_o
   );
endinterface

// File: rtl/muldiv_core.sv
// Unsigned iterative datapath: radix-2 shift-add multiply or restoring divide,
// one bit per step. Exposes next-step values so the caller can capture the
// final result on the same edge as the last step.
module muldiv_core (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load_i,
   input  logic        step_i,
   input  logic        is_div_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic        last_o,
   output logic [63:0] prod_o,
   output logic [31:0] quot_o,
   output logic [31:0] rem_o
);

   logic [4:0]  cnt_q;
   logic        is_div_q;
   logic [31:0] a_q;
   logic [31:0] b_q;
   logic [63:0] prod_q;
   logic [31:0] quot_q;
   logic [31:0] rem_q;

   logic [32:0] add_sum;
   logic [63:0] prod_d;
   logic [32:0] shifted;
   logic [32:0] diff;
   logic [31:0] rem_d;
   logic [31:0] quot_d;

   // Multiply: add multiplicand into the upper half when the current LSB is set,
   // then shift right; the carry becomes the new MSB.
   assign add_sum = {1'b0, prod_q[63:32]} + {1'b0, (prod_q[0] ? a_q : 32'd0)};
   assign prod_d  = {add_sum, prod_q[31:1]};

   // Divide: 33-bit trial subtract; bit 32 of the difference is the borrow.
   assign shifted = {rem_q, quot_q[31]};
   assign diff    = shifted - {1'b0, b_q};
   assign rem_d   = diff[32] ? shifted[31:0] : diff[31:0];
   assign quot_d  = {quot_q[30:0], ~diff[32]};

   assign last_o = (cnt_q == 5'd0);
   assign prod_o = prod_d;
   assign quot_o = quot_d;
   assign rem_o  = rem_d;

   // Load operands on start, then advance one bit per step.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, regardless of statement order.
      if (!rst_n) begin
         cnt_q    <= 5'd0;
         is_div_q <= 1'b0;
         a_q      <= 32'd0;
         b_q      <= 32'd0;
         prod_q   <= 64'd0;
         quot_q   <= 32'd0;
         rem_q    <= 32'd0;
      end else if (load_i) begin
         cnt_q    <= 5'd31;
         is_div_q <= is_div_i;
         a_q      <= a_i;
         b_q      <= b_i;
         prod_q   <= {32'd0, b_i};
         quot_q   <= a_i;
         rem_q    <= 32'd0;
      end else if (step_i) begin
         cnt_q <= cnt_q - 5'd1;
         if (is_div_q) begin
            quot_q <= quot_d;
            rem_q  <= rem_d;
         end else begin
            prod_q <= prod_d;
         end
      end
   end

endmodule

// File: rtl/execute_muldiv.sv
// Execute-stage RV32M unit: FSM, operand sign conditioning, divide fast path,
// flush handling and registered result outputs around muldiv_core.
module execute_muldiv
   import muldiv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input logic             clk,
   input logic             rst_n,
   execute_muldiv_if.slave bus
);

   muldiv_state_t state_q;
   muldiv_op_t    op_q;
   logic          neg_a_q;
   logic          neg_b_q;
   logic [4:0]    rd_q;
   logic          done_q;
   logic [31:0]   result_q;
   logic [4:0]    rd_out_q;

   muldiv_op_t    op_in;
   logic          signed_a;
   logic          signed_b;
   logic          neg_a;
   logic          neg_b;
   logic [XLEN-1:0] mag_a;
   logic [XLEN-1:0] mag_b;
   logic          div_zero;
   logic          div_ovf;
   logic          fast;
   logic          accept;
   logic [31:0]   fast_res;
   logic [31:0]   calc_res;

   logic          core_last;
   logic [63:0]   core_prod;
   logic [31:0]   core_quot;
   logic [31:0]   core_rem;

   assign op_in = muldiv_op_t'(bus.funct3_i);

   // Decide which operands are interpreted as signed for the incoming op.
   always_comb begin
      // NOTE: defaults before the case keep every path assigned, so no latch.
      signed_a = 1'b0;
      signed_b = 1'b0;
      case (op_in)
         OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
            signed_a = 1'b1;
            signed_b = 1'b1;
         end
         OP_MULHSU: signed_a = 1'b1;
         default: ;
      endcase
   end

   // |INT_MIN| wraps to INT_MIN, which is the right magnitude read as unsigned.
   assign neg_a = signed_a & bus.op_a_i[31];
   assign neg_b = signed_b & bus.op_b_i[31];
   assign mag_a = neg_a ? -bus.op_a_i : bus.op_a_i;
   assign mag_b = neg_b ? -bus.op_b_i : bus.op_b_i;

   // Cases with a fixed architectural answer skip the iterative datapath.
   assign div_zero = bus.funct3_i[2] && (bus.op_b_i == 32'd0);
   assign div_ovf  = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
                     (bus.op_a_i == INT_MIN) && (bus.op_b_i == 32'hFFFF_FFFF);
   assign fast     = div_zero | div_ovf;

   // funct3[1] separates remainder ops from quotient ops within the divides.
   assign fast_res = div_zero ? (bus.funct3_i[1] ? bus.op_a_i : DIV0_QUOT)
                              : (bus.funct3_i[1] ? 32'd0      : INT_MIN);

   assign accept = (state_q == ST_IDLE) && bus.start_i && !bus.flush_i;

   muldiv_core u_core (
      .clk      (clk),
      .rst_n    (rst_n),
      .load_i   (accept && !fast),
      .step_i   ((state_q == ST_CALC) && !bus.flush_i),
      .is_div_i (bus.funct3_i[2]),
      .a_i      (mag_a),
      .b_i      (mag_b),
      .last_o   (core_last),
      .prod_o   (core_prod),
      .quot_o   (core_quot),
      .rem_o    (core_rem)
   );

   assign calc_res = sign_fix(op_q, neg_a_q, neg_b_q, core_prod, core_quot, core_rem);

   // Control FSM with registered completion outputs; flush always returns to IDLE.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         op_q     <= OP_MUL;
         neg_a_q  <= 1'b0;
         neg_b_q  <= 1'b0;
         rd_q     <= 5'd0;
         done_q   <= 1'b0;
         result_q <= 32'd0;
         rd_out_q <= 5'd0;
      end else begin
         done_q <= 1'b0;
         if (bus.flush_i) begin
            state_q <= ST_IDLE;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (bus.start_i) begin
                     if (fast) begin
                        state_q  <= ST_DONE;
                        done_q   <= 1'b1;
                        result_q <= fast_res;
                        rd_out_q <= bus.rd_i;
                     end else begin
                        state_q <= ST_CALC;
                        op_q    <= op_in;
                        neg_a_q <= neg_a;
                        neg_b_q <= neg_b;
                        rd_q    <= bus.rd_i;
                     end
                  end
               end
               ST_CALC: begin
                  if (core_last) begin
                     state_q  <= ST_DONE;
                     done_q   <= 1'b1;
                     result_q <= calc_res;
                     rd_out_q <= rd_q;
                  end
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign bus.stall_o  = !bus.flush_i &&
                         (((state_q == ST_IDLE) && bus.start_i) || (state_q == ST_CALC));
   assign bus.done_o   = done_q && !bus.flush_i;
   assign bus.result_o = result_q;
   assign bus.rd_o     = rd_out_q;

endmodule

// File: tb/tb_execute_muldiv.sv
// Directed bench for execute_muldiv: results, latency, stall window, fast path,
// flush abort and mid-operation reset.
module tb_execute_muldiv;

   logic clk = 1'b0;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;

   execute_muldiv_if bus();

   execute_muldiv #(.XLEN(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one op, measure done latency and stall window, check result/rd.
   task automatic run_op(input string tag, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp,
                         input int exp_lat);
      int lat;
      int stall_cycles;
      lat          = 0;
      stall_cycles = 0;
      bus.start_i  = 1'b1;
      bus.funct3_i = f3;
      bus.op_a_i   = a;
      bus.op_b_i   = b;
      bus.rd_i     = rd;
      #1;
      if (bus.stall_o) stall_cycles++;
      tick();
      bus.start_i = 1'b0;
      bus.op_a_i  = 32'd0;
      bus.op_b_i  = 32'd0;
      bus.rd_i    = 5'd0;
      for (int i = 1; i <= 40; i++) begin
         if (bus.done_o) begin
            lat = i;
            break;
         end
         if (bus.stall_o) stall_cycles++;
         tick();
      end
      check({tag, " latency"}, lat, exp_lat);
      check({tag, " stall cycles"}, stall_cycles, exp_lat);
      check({tag, " stall in done"}, bus.stall_o, 1'b0);
      check({tag, " result"}, bus.result_o, exp);
      check({tag, " rd"}, bus.rd_o, rd);
      tick();
      check({tag, " done drops"}, bus.done_o, 1'b0);
      check({tag, " result holds"}, bus.result_o, exp);
   endtask

   initial begin
      int done_seen;
      rst_n        = 1'b0;
      bus.start_i  = 1'b0;
      bus.funct3_i = 3'd0;
      bus.op_a_i   = 32'd0;
      bus.op_b_i   = 32'd0;
      bus.rd_i     = 5'd0;
      bus.flush_i  = 1'b0;
      repeat (2) tick();
      check("reset done", bus.done_o, 1'b0);
      check("reset result", bus.result_o, 32'd0);
      check("reset rd", bus.rd_o, 5'd0);
      check("reset stall", bus.stall_o, 1'b0);
      rst_n = 1'b1;
      tick();

      // Multiplies
      run_op("MUL 7*-3",       3'd0, 32'd7,        32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 33);
      run_op("MULHU -1*-1",    3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFE, 33);
      run_op("MULH -1*-1",     3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'h0000_0000, 33);
      run_op("MULHSU -1*2",    3'd2, 32'hFFFF_FFFF, 32'd2,         5'd8,  32'hFFFF_FFFF, 33);

      // Divides
      run_op("DIV -7/2",       3'd4, 32'hFFFF_FFF9, 32'd2,         5'd10, 32'hFFFF_FFFD, 33);
      run_op("REM -7/2",       3'd6, 32'hFFFF_FFF9, 32'd2,         5'd11, 32'hFFFF_FFFF, 33);
      run_op("DIVU 100/7",     3'd5, 32'd100,       32'd7,         5'd12, 32'd14,        33);
      run_op("REMU 100/7",     3'd7, 32'd100,       32'd7,         5'd13, 32'd2,         33);
      run_op("DIV 20/-3",      3'd4, 32'd20,        32'hFFFF_FFFD, 5'd14, 32'hFFFF_FFFA, 33);
      run_op("REM 20/-3",      3'd6, 32'd20,        32'hFFFF_FFFD, 5'd15, 32'd2,         33);
      run_op("DIV INT_MIN/1",  3'd4, 32'h8000_0000, 32'd1,         5'd16, 32'h8000_0000, 33);

      // Fast path
      run_op("DIVU 5/0",       3'd5, 32'd5,         32'd0,         5'd17, 32'hFFFF_FFFF, 1);
      run_op("REM 5/0",        3'd6, 32'd5,         32'd0,         5'd18, 32'd5,         1);
      run_op("DIV ovf",        3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd19, 32'h8000_0000, 1);
      run_op("REM ovf",        3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd20, 32'd0,         1);

      // Flush in CALC cycle 10
      bus.start_i  = 1'b1;
      bus.funct3_i = 3'd0;
      bus.op_a_i   = 32'h1234;
      bus.op_b_i   = 32'd5;
      bus.rd_i     = 5'd9;
      tick();
      bus.start_i = 1'b0;
      repeat (9) tick();
      check("flush pre stall", bus.stall_o, 1'b1);
      bus.flush_i = 1'b1;
      #1;
      check("flush stall drop", bus.stall_o, 1'b0);
      check("flush no done", bus.done_o, 1'b0);
      tick();
      bus.flush_i = 1'b0;
      #1;
      check("post flush idle stall", bus.stall_o, 1'b0);
      check("post flush no done", bus.done_o, 1'b0);
      check("post flush result kept", bus.result_o, 32'd0);
      run_op("DIVU 9/3 after flush", 3'd5, 32'd9, 32'd3, 5'd4, 32'd3, 33);

      // Reset in the middle of CALC
      bus.start_i  = 1'b1;
      bus.funct3_i = 3'd0;
      bus.op_a_i   = 32'h10;
      bus.op_b_i   = 32'h10;
      bus.rd_i     = 5'd21;
      tick();
      bus.start_i = 1'b0;
      repeat (5) tick();
      rst_n = 1'b0;
      tick();
      check("mid reset result", bus.result_o, 32'd0);
      check("mid reset rd", bus.rd_o, 5'd0);
      check("mid reset done", bus.done_o, 1'b0);
      check("mid reset stall", bus.stall_o, 1'b0);
      rst_n     = 1'b1;
      done_seen = 0;
      for (int i = 0; i < 36; i++) begin
         tick();
         if (bus.done_o) done_seen++;
      end
      check("no done after reset", done_seen, 0);
      run_op("MUL 3*4 after reset", 3'd0, 32'd3, 32'd4, 5'd2, 32'd12, 33);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
